// File: rtl/gate_seq_scheduler.sv
// Sequencer for gateStateMult: loads a state and a gate stream, holds each gate's operands for MULT_LAT cycles, then writes the result back as the new state.
// Latency: ld_ready drops for exactly MULT_LAT cycles per gate; the final state streams out on rd_* and is followed one cycle later by a done pulse.
// Backpressure: ld_valid gaps and rd_ready stalls hold all indices. `define ABORT_SCHED_EN adds an abort input.
module gate_seq_scheduler #(
    parameter int N        = 2,
    parameter int W        = 16,
    parameter int MULT_LAT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef ABORT_SCHED_EN
    input  logic                      abort,
`endif
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [2*W-1:0]            ld_data,
    input  logic                      ld_last,
    output logic [(2**N)*2*W-1:0]     mult_state,
    output logic [(4**N)*2*W-1:0]     mult_gate,
    input  logic [(2**N)*2*W-1:0]     mult_out,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [2*W-1:0]            rd_data,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                gate_count
);
    localparam int EW = 2*W;
    localparam int NS = 2**N;
    localparam int NG = 4**N;
    localparam int CW = $clog2(MULT_LAT+1);

    typedef enum logic [1:0] {
        S_LOAD_STATE = 2'd0,
        S_LOAD_GATE  = 2'd1,
        S_WAIT       = 2'd2,
        S_SEND       = 2'd3
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [EW-1:0]    r_state [NS];
    logic [EW-1:0]    r_gate  [NG];
    logic [N-1:0]     r_idx;
    logic [N-1:0]     r_row;
    logic [N-1:0]     r_col;
    logic [CW-1:0]    r_cnt;
    logic             r_last_f;
    logic             r_done;
    logic [7:0]       r_gate_count;
    logic             w_ld_state;
    logic             w_ld_beat;
    logic             w_rd_beat;
    logic             w_gate_end;
    logic             w_abort;

`ifdef ABORT_SCHED_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // ld_ready is also gated by reset so it stays low while reset is held.
    assign ld_ready   = reset & w_ld_state;
    assign w_ld_beat  = ld_valid & ld_ready;
    assign w_rd_beat  = rd_valid & rd_ready;
    assign w_gate_end = &{r_row, r_col};
    assign rd_data    = r_state[r_idx];
    assign done       = r_done;
    assign gate_count = r_gate_count;

    for (genvar g = 0; g < NS; g++) begin : g_state_out
        assign mult_state[g*EW +: EW] = r_state[g];
    end
    for (genvar g = 0; g < NG; g++) begin : g_gate_out
        assign mult_gate[g*EW +: EW] = r_gate[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_fsm <= S_LOAD_STATE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_ld_state = 1'b0;
        rd_valid   = 1'b0;
        busy       = 1'b0;
        case (r_fsm)
            S_LOAD_STATE: begin
                w_ld_state = 1'b1;
                if (w_ld_beat && (&r_idx)) w_fsm_nxt = S_LOAD_GATE;
            end
            S_LOAD_GATE: begin
                w_ld_state = 1'b1;
                if (w_ld_beat && w_gate_end) w_fsm_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_cnt == CW'(1)) w_fsm_nxt = r_last_f ? S_SEND : S_LOAD_GATE;
            end
            S_SEND: begin
                rd_valid = 1'b1;
                if (w_rd_beat && (&r_idx)) w_fsm_nxt = S_LOAD_STATE;
            end
            default: w_fsm_nxt = S_LOAD_STATE;
        endcase
        if (w_abort) w_fsm_nxt = S_LOAD_STATE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NS; i++) r_state[i] <= '0;
            for (int i = 0; i < NG; i++) r_gate[i]  <= '0;
            r_idx        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_cnt        <= '0;
            r_last_f     <= 1'b0;
            r_done       <= 1'b0;
            r_gate_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Abort drops any partial transfer but keeps operands and gate_count.
                r_idx <= '0;
                r_row <= '0;
                r_col <= '0;
                r_cnt <= '0;
            end else begin
                case (r_fsm)
                    S_LOAD_STATE: if (w_ld_beat) begin
                        r_state[r_idx] <= ld_data;
                        r_idx          <= r_idx + 1'b1;
                        if (r_idx == '0) r_gate_count <= '0;
                    end
                    S_LOAD_GATE: if (w_ld_beat) begin
                        r_gate[{r_row, r_col}] <= ld_data;
                        r_col                  <= r_col + 1'b1;
                        if (&r_col) r_row <= r_row + 1'b1;
                        if (w_gate_end) begin
                            r_last_f <= ld_last;
                            r_cnt    <= CW'(MULT_LAT);
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt == CW'(1)) begin
                            for (int i = 0; i < NS; i++) r_state[i] <= mult_out[i*EW +: EW];
                            r_cnt <= '0;
                            if (r_gate_count != 8'hFF) r_gate_count <= r_gate_count + 8'd1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SEND: if (w_rd_beat) begin
                        r_idx <= r_idx + 1'b1;
                        if (&r_idx) r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
